// File: rtl/nvic_irq_arbiter.sv
// nvic_irq_arbiter: sticky pending latch, per-line priority arbitration and request/ack/done tracking
module nvic_irq_arbiter #(
  parameter int NUM_IRQ = 21,
  parameter int PRIO_W  = 4,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_pulse_i,
  input  logic [NUM_IRQ-1:0] irq_enable_i,
  input  logic [NUM_IRQ-1:0] pend_clr_i,
  input  logic               prio_wr_en_i,
  input  logic [ID_W-1:0]    prio_wr_idx_i,
  input  logic [PRIO_W-1:0]  prio_wr_data_i,
  input  logic               irq_ack_i,
  input  logic               irq_done_i,
  output logic               irq_req_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic [PRIO_W-1:0]  irq_prio_o,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic               active_valid_o,
  output logic [ID_W-1:0]    active_id_o
);
  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_e;
  state_e state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d, elig, ack_mask;
  logic [PRIO_W-1:0] prio_q [NUM_IRQ];
  logic [ID_W-1:0] win_id, irq_id_q, irq_id_d, active_id_q, active_id_d;
  logic [PRIO_W-1:0] win_prio, irq_prio_q, irq_prio_d;
  logic any_elig, ack_acc, irq_req_q, irq_req_d, active_valid_q, active_valid_d;

  assign elig      = pending_q & irq_enable_i;
  assign any_elig  = |elig;
  assign ack_acc   = state_q == REQ && irq_ack_i;
  assign ack_mask  = ack_acc ? NUM_IRQ'(1) << irq_id_q : '0;
  assign pending_d = (pending_q & ~(pend_clr_i | ack_mask)) | irq_pulse_i;

  // scan high to low with <= so the lowest index wins among equal priorities
  always_comb begin
    win_id   = '0;
    win_prio = '1;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (elig[k] && prio_q[k] <= win_prio) begin
        win_id   = ID_W'(k);
        win_prio = prio_q[k];
      end
    end
  end

  // next state: acks only count while a request is presented, done only while active
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_elig ? REQ : IDLE;
      REQ:     state_d = irq_ack_i ? ACTIVE : any_elig ? REQ : IDLE;
      ACTIVE:  state_d = irq_done_i ? IDLE : ACTIVE;
      default: state_d = IDLE;
    endcase
  end

  // registered outputs: the presented id tracks the live winner while requesting
  always_comb begin
    irq_req_d      = state_d == REQ;
    irq_id_d       = irq_req_d ? win_id : irq_id_q;
    irq_prio_d     = irq_req_d ? win_prio : irq_prio_q;
    active_valid_d = state_d == ACTIVE;
    active_id_d    = ack_acc ? irq_id_q : active_id_q;
  end

  // state and handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      irq_req_q      <= 1'b0;
      irq_id_q       <= '0;
      irq_prio_q     <= '0;
      active_valid_q <= 1'b0;
      active_id_q    <= '0;
    end else begin
      state_q        <= state_d;
      irq_req_q      <= irq_req_d;
      irq_id_q       <= irq_id_d;
      irq_prio_q     <= irq_prio_d;
      active_valid_q <= active_valid_d;
      active_id_q    <= active_id_d;
    end
  end

  // pending latch and priority table; out-of-range priority writes are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      for (int k = 0; k < NUM_IRQ; k++) prio_q[k] <= '0;
    end else begin
      pending_q <= pending_d;
      if (prio_wr_en_i && 32'(prio_wr_idx_i) < NUM_IRQ) prio_q[prio_wr_idx_i] <= prio_wr_data_i;
    end
  end

  assign irq_req_o      = irq_req_q;
  assign irq_id_o       = irq_id_q;
  assign irq_prio_o     = irq_prio_q;
  assign pending_o      = pending_q;
  assign active_valid_o = active_valid_q;
  assign active_id_o    = active_id_q;
endmodule

// File: tb/tb_nvic_irq_arbiter.sv
// tb_nvic_irq_arbiter: directed scenarios plus random traffic checked against a behavioural model
module tb_nvic_irq_arbiter;
  localparam int N = 21, PW = 4, IW = 5;
  logic clk = 1'b0, rst;
  logic [N-1:0] pulse, en, clr;
  logic we, ack, done;
  logic [IW-1:0] widx;
  logic [PW-1:0] wdata;
  logic req, av;
  logic [IW-1:0] id, aid;
  logic [PW-1:0] pr;
  logic [N-1:0] pend;
  int n_chk = 0, n_pass = 0;

  bit [N-1:0] m_pend;
  int m_prio [N];
  int m_state, m_id, m_pr, m_aid;
  bit m_req, m_av;

  always #5 clk = ~clk;

  nvic_irq_arbiter #(.NUM_IRQ(N), .PRIO_W(PW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .irq_pulse_i(pulse), .irq_enable_i(en), .pend_clr_i(clr),
    .prio_wr_en_i(we), .prio_wr_idx_i(widx), .prio_wr_data_i(wdata),
    .irq_ack_i(ack), .irq_done_i(done),
    .irq_req_o(req), .irq_id_o(id), .irq_prio_o(pr), .pending_o(pend),
    .active_valid_o(av), .active_id_o(aid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int best(input bit [N-1:0] elig);
    int b = -1;
    for (int k = 0; k < N; k++)
      if (elig[k] && (b < 0 || m_prio[k] * N + k < m_prio[b] * N + b)) b = k;
    return b;
  endfunction

  task automatic model_step();
    bit [N-1:0] np;
    int w;
    if (rst) begin
      m_pend = '0; m_state = 0; m_req = 0; m_id = 0; m_pr = 0; m_av = 0; m_aid = 0;
      for (int k = 0; k < N; k++) m_prio[k] = 0;
      return;
    end
    w = best(m_pend & en);
    np = m_pend & ~clr;
    if (m_state == 1 && ack) np[m_id] = 1'b0;
    np |= pulse;
    if (m_state == 0) begin
      if (w >= 0) begin m_state = 1; m_req = 1; m_id = w; m_pr = m_prio[w]; end
    end else if (m_state == 1) begin
      if (ack) begin m_state = 2; m_req = 0; m_av = 1; m_aid = m_id; end
      else if (w < 0) begin m_state = 0; m_req = 0; end
      else begin m_id = w; m_pr = m_prio[w]; end
    end else if (done) begin
      m_state = 0; m_av = 0;
    end
    if (we && widx < N) m_prio[widx] = wdata;
    m_pend = np;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("pending", pend, m_pend);
    chk("irq_req", req, m_req);
    if (m_req) chk("irq_id", id, m_id);
    if (m_req) chk("irq_prio", pr, m_pr);
    chk("active_valid", av, m_av);
    if (m_av) chk("active_id", aid, m_aid);
  endtask

  task automatic quiet();
    pulse = '0; clr = '0; we = 0; ack = 0; done = 0; rst = 0;
  endtask

  initial begin
    quiet(); en = '0; widx = '0; wdata = '0; rst = 1;
    tick();
    chk("rst_pending", pend, 0);
    chk("rst_req", req, 0);
    chk("rst_id", id, 0);
    chk("rst_av", av, 0);
    rst = 0; en = '1;
    pulse[5] = 1; tick(); quiet();
    chk("single_pend5", pend[5], 1);
    tick();
    chk("single_req", req, 1);
    chk("single_id", id, 5);
    chk("single_prio", pr, 0);
    ack = 1; tick(); quiet();
    chk("single_ack_pend", pend[5], 0);
    chk("single_av", av, 1);
    chk("single_aid", aid, 5);
    done = 1; tick(); quiet();
    chk("single_done", av, 0);
    we = 1; widx = 3; wdata = 2; tick();
    widx = 7; wdata = 1; tick();
    widx = 9; wdata = 1; tick(); quiet();
    pulse[3] = 1; pulse[7] = 1; pulse[9] = 1; tick(); quiet();
    tick();
    chk("tie_first", id, 7);
    ack = 1; tick(); quiet(); done = 1; tick(); quiet(); tick();
    chk("tie_second", id, 9);
    ack = 1; tick(); quiet(); done = 1; tick(); quiet(); tick();
    chk("tie_third", id, 3);
    ack = 1; tick(); quiet(); done = 1; tick(); quiet();
    we = 1; widx = 4; wdata = 5; tick(); widx = 10; wdata = 1; tick(); quiet();
    pulse[4] = 1; tick(); quiet(); tick();
    chk("rearb_first", id, 4);
    pulse[10] = 1; tick(); quiet(); tick();
    chk("rearb_switch", id, 10);
    ack = 1; tick(); quiet();
    chk("rearb_aid", aid, 10);
    chk("rearb_pend4", pend[4], 1);
    done = 1; tick(); quiet(); tick(); ack = 1; tick(); quiet(); done = 1; tick(); quiet();
    pulse[2] = 1; tick(); quiet(); tick();
    chk("sbc_id", id, 2);
    ack = 1; pulse[2] = 1; tick(); quiet();
    chk("sbc_aid", aid, 2);
    chk("sbc_pend", pend[2], 1);
    done = 1; tick(); quiet(); tick();
    chk("sbc_again", id, 2);
    ack = 1; tick(); quiet(); done = 1; tick(); quiet();
    pulse[6] = 1; tick(); quiet(); tick();
    chk("wd_id", id, 6);
    en[6] = 0; tick();
    chk("wd_req", req, 0);
    chk("wd_pend", pend[6], 1);
    en[6] = 1; tick(); tick();
    chk("wd_rereq", id, 6);
    clr[6] = 1; tick(); quiet();
    chk("wd_clr", pend[6], 0);
    tick();
    pulse[0] = 1; tick(); quiet(); tick(); ack = 1; tick(); quiet();
    pulse[0] = 1; pulse[4] = 1; tick(); quiet();
    chk("mid_pend", pend, 21'h00011);
    rst = 1; pulse[1] = 1; tick(); quiet();
    chk("mid_rst_pend", pend, 0);
    chk("mid_rst_av", av, 0);
    chk("mid_rst_req", req, 0);
    we = 1; widx = 21; wdata = 15; tick(); quiet();
    pulse[3] = 1; pulse[7] = 1; tick(); quiet(); tick();
    chk("mid_prio_id", id, 3);
    chk("mid_prio_val", pr, 0);
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < N; k++) begin
        pulse[k] = $urandom_range(15) == 0;
        en[k] = $urandom_range(7) != 0;
        clr[k] = $urandom_range(31) == 0;
      end
      we = $urandom_range(3) == 0;
      widx = IW'($urandom_range(31));
      wdata = PW'($urandom_range(15));
      ack = $urandom_range(2) == 0;
      done = $urandom_range(3) == 0;
      rst = $urandom_range(199) == 0;
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
